// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the run controller.
// Holds the controller state encoding, the run-end cause codes and the
// instruction-set constants that the controller needs to detect a halt.
package cpu_run_ctrl_pkg;

    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned INSTR_W = 8;

    // Opcode field [7:6] of a JUMP; target is in [3:0].
    localparam logic [1:0] OP_JUMP = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRun,
        StPause,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        CauseHalt    = 2'b00,
        CausePcRange = 2'b01,
        CauseTimeout = 2'b10,
        CauseStop    = 2'b11
    } done_cause_e;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Instruction-load channel of the run controller.
// master : loader side, drives load_valid / load_addr / load_data
// slave  : controller side, returns load_ready
// A word is written on a clock edge where load_valid and load_ready are both high.
interface cpu_run_ctrl_if;
    import cpu_run_ctrl_pkg::*;

    logic                 load_valid;
    logic                 load_ready;
    logic [ADDR_W-1:0]    load_addr;
    logic [INSTR_W-1:0]   load_data;

    modport master (
        output load_valid,
        output load_addr,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_addr,
        input  load_data,
        output load_ready
    );

endinterface

// File: rtl/cpu_imem.sv
// Instruction memory: DEPTH x 8, synchronous write, asynchronous read.
// Contents are not reset, so a loaded program survives a controller reset.
// Ports:
//   clk    clock
//   we     write enable (sampled on rising edge)
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data, combinational from raddr
module cpu_imem
    import cpu_run_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for a small core: owns the instruction memory, sequences
// clear/run/pause/single-step, and ends a run on stop, self-jump halt,
// PC out of range or cycle limit.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   load                 instruction-load channel (slave side)
//   start/step/resume/stop  single-cycle control pulses; pause is a level
//   core_pc              core program counter
//   instr                instruction presented to the core
//   core_en              qualifies every core PC / register-file update
//   core_reset           synchronous clear pulse to the core
//   busy, done           status (busy in CLEAR/RUN/PAUSE, done in DONE)
//   done_cause           why the last run ended
//   cycle_count          core-enabled cycles in the current run (saturating)
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int unsigned MAX_CYCLES = 1000,
    parameter int unsigned MEM_DEPTH  = 16
) (
    input  logic                clk,
    input  logic                reset,
    cpu_run_ctrl_if.slave       load,
    input  logic                start,
    input  logic                pause,
    input  logic                step,
    input  logic                resume,
    input  logic                stop,
    input  logic [7:0]          core_pc,
    output logic [INSTR_W-1:0]  instr,
    output logic                core_en,
    output logic                core_reset,
    output logic                busy,
    output logic                done,
    output logic [1:0]          done_cause,
    output logic [15:0]         cycle_count
);

    state_e             state_q, state_d;
    done_cause_e        cause_q, cause_d;
    logic [15:0]        count_q, count_d;
    logic               core_reset_q, busy_q, done_q, load_ready_q;

    logic [INSTR_W-1:0] mem_rdata;
    logic               load_we;
    logic               pc_oor, halt, timeout, end_hit;
    done_cause_e        end_cause;

    assign load_we = load.load_valid & load_ready_q;

    cpu_imem #(
        .DEPTH (MEM_DEPTH)
    ) u_imem (
        .clk   (clk),
        .we    (load_we),
        .waddr (load.load_addr),
        .wdata (load.load_data),
        .raddr (core_pc[ADDR_W-1:0]),
        .rdata (mem_rdata)
    );

    assign pc_oor = (core_pc >= 8'(MEM_DEPTH));
    // Out-of-range fetches see a harmless word so no spurious halt is decoded.
    assign instr  = pc_oor ? '0 : mem_rdata;

    always_comb begin
        halt    = (instr[7:6] == OP_JUMP) && (instr[3:0] == core_pc[3:0]);
        timeout = (count_q == 16'(MAX_CYCLES));

        // Run-end checks in priority order; stop outranks everything.
        end_hit   = 1'b1;
        end_cause = CauseStop;
        if (stop) begin
            end_cause = CauseStop;
        end else if (halt) begin
            end_cause = CauseHalt;
        end else if (pc_oor) begin
            end_cause = CausePcRange;
        end else if (timeout) begin
            end_cause = CauseTimeout;
        end else begin
            end_hit = 1'b0;
        end

        state_d = state_q;
        cause_d = cause_q;
        core_en = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StClear;
                    cause_d = CauseHalt;
                end
            end
            StClear: begin
                state_d = StRun;
            end
            StRun: begin
                if (end_hit) begin
                    state_d = StDone;
                    cause_d = end_cause;
                end else if (pause) begin
                    state_d = StPause;
                end else begin
                    core_en = 1'b1;
                end
            end
            StPause: begin
                // end_hit with stop always carries CauseStop, so stop wins over step.
                if (end_hit && (stop || step)) begin
                    state_d = StDone;
                    cause_d = end_cause;
                end else if (step) begin
                    core_en = 1'b1;
                end else if (resume) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        count_d = count_q;
        if (state_d == StClear) begin
            count_d = '0;
        end else if (core_en && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    // State and registered outputs, all derived from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cause_q      <= CauseHalt;
            count_q      <= '0;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cause_q      <= cause_d;
            count_q      <= count_d;
            core_reset_q <= (state_d == StClear);
            busy_q       <= (state_d inside {StClear, StRun, StPause});
            done_q       <= (state_d == StDone);
            load_ready_q <= (state_d inside {StIdle, StDone});
        end
    end

    assign load.load_ready = load_ready_q;
    assign core_reset      = core_reset_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign done_cause      = cause_q;
    assign cycle_count     = count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl. Two instances: dut_a with the default
// cycle limit and dut_b with MAX_CYCLES=5. Each has a small behavioural core:
//   00 rr iiii  ADDI r[rr] += sext(iiii)
//   01 rr ss xx ADD  r[rr] += r[ss]
//   10 rr tttt  BNZ  if r[rr] != 0 pc = tttt
//   11 xx tttt  JUMP pc = tttt
// Expected run results are queued before each start; a monitor pops one on
// every rising edge of done and compares cause, cycle count and core state.
module tb_cpu_run_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0;
    logic pause = 1'b0, step = 1'b0, resume = 1'b0, stop = 1'b0;

    logic [7:0]  pc_a, pc_b, instr_a, instr_b;
    logic        en_a, en_b, crst_a, crst_b, busy_a, busy_b, done_a, done_b;
    logic [1:0]  cause_a, cause_b;
    logic [15:0] cnt_a, cnt_b;

    cpu_run_ctrl_if bus_a ();
    cpu_run_ctrl_if bus_b ();

    always #5 clk = ~clk;

    cpu_run_ctrl dut_a (
        .clk         (clk),
        .reset       (reset),
        .load        (bus_a),
        .start       (start_a),
        .pause       (pause),
        .step        (step),
        .resume      (resume),
        .stop        (stop),
        .core_pc     (pc_a),
        .instr       (instr_a),
        .core_en     (en_a),
        .core_reset  (crst_a),
        .busy        (busy_a),
        .done        (done_a),
        .done_cause  (cause_a),
        .cycle_count (cnt_a)
    );

    cpu_run_ctrl #(
        .MAX_CYCLES (5)
    ) dut_b (
        .clk         (clk),
        .reset       (reset),
        .load        (bus_b),
        .start       (start_b),
        .pause       (pause),
        .step        (step),
        .resume      (resume),
        .stop        (stop),
        .core_pc     (pc_b),
        .instr       (instr_b),
        .core_en     (en_b),
        .core_reset  (crst_b),
        .busy        (busy_b),
        .done        (done_b),
        .done_cause  (cause_b),
        .cycle_count (cnt_b)
    );

    // ---------------- core models ----------------
    typedef struct packed {
        logic [7:0]      pc;
        logic [3:0][7:0] r;
    } core_t;

    core_t core_a, core_b;

    function automatic core_t core_exec(input core_t c, input logic [7:0] ins);
        core_t n = c;
        n.pc = c.pc + 8'd1;
        case (ins[7:6])
            2'b00: n.r[ins[5:4]] = c.r[ins[5:4]] + {{4{ins[3]}}, ins[3:0]};
            2'b01: n.r[ins[5:4]] = c.r[ins[5:4]] + c.r[ins[3:2]];
            2'b10: if (c.r[ins[5:4]] != 8'd0) n.pc = {4'd0, ins[3:0]};
            default: n.pc = {4'd0, ins[3:0]};
        endcase
        return n;
    endfunction

    always_ff @(posedge clk) begin
        if (crst_a) core_a <= '0;
        else if (en_a) core_a <= core_exec(core_a, instr_a);
    end

    always_ff @(posedge clk) begin
        if (crst_b) core_b <= '0;
        else if (en_b) core_b <= core_exec(core_b, instr_b);
    end

    assign pc_a = core_a.pc;
    assign pc_b = core_b.pc;

    // ---------------- scoreboard ----------------
    typedef struct {
        string       name;
        logic [1:0]  cause;
        logic [15:0] count;
        logic [7:0]  pc;
        logic [7:0]  r2;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic expect_done(input int sel, input string name, input logic [1:0] cause,
                               input logic [15:0] count, input logic [7:0] pc,
                               input logic [7:0] r2);
        exp_t e;
        e.name = name; e.cause = cause; e.count = count; e.pc = pc; e.r2 = r2;
        if (sel == 0) q_a.push_back(e);
        else q_b.push_back(e);
    endtask

    task automatic on_done(input int sel);
        exp_t        e;
        logic [1:0]  c;
        logic [15:0] n;
        core_t       k;
        if (sel == 0) begin
            c = cause_a; n = cnt_a; k = core_a;
        end else begin
            c = cause_b; n = cnt_b; k = core_b;
        end
        if ((sel == 0 && q_a.size() == 0) || (sel == 1 && q_b.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done dut%0d: done rose, required no done", sel);
            return;
        end
        if (sel == 0) e = q_a.pop_front();
        else e = q_b.pop_front();
        check({e.name, " cause"}, 32'(c), 32'(e.cause));
        check({e.name, " cycle_count"}, 32'(n), 32'(e.count));
        check({e.name, " core_pc"}, 32'(k.pc), 32'(e.pc));
        check({e.name, " core_r2"}, 32'(k.r[2]), 32'(e.r2));
    endtask

    logic prev_a, prev_b;

    initial begin
        prev_a = 1'b0;
        prev_b = 1'b0;
        forever begin
            @(negedge clk);
            if (done_a && !prev_a) on_done(0);
            if (done_b && !prev_b) on_done(1);
            prev_a = done_a;
            prev_b = done_b;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input int sel, input logic [3:0] addr, input logic [7:0] data);
        if (sel == 0) begin
            bus_a.load_valid = 1'b1; bus_a.load_addr = addr; bus_a.load_data = data;
        end else begin
            bus_b.load_valid = 1'b1; bus_b.load_addr = addr; bus_b.load_data = data;
        end
        tick();
        bus_a.load_valid = 1'b0;
        bus_b.load_valid = 1'b0;
    endtask

    task automatic wait_done(input int sel, input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if ((sel == 0 && done_a) || (sel == 1 && done_b)) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL %s timeout: done=0 after %0d cycles, required 1", name, budget);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    logic [7:0] sum_prog [11];

    initial begin
        bus_a.load_valid = 1'b0; bus_a.load_addr = '0; bus_a.load_data = '0;
        bus_b.load_valid = 1'b0; bus_b.load_addr = '0; bus_b.load_data = '0;
        sum_prog = '{8'h05, 8'h04, 8'h10, 8'h60, 8'h0F, 8'h83,
                     8'h11, 8'h11, 8'h37, 8'h31, 8'hCA};

        @(negedge clk);
        tick();
        tick();
        check("reset core_reset", 32'(crst_a), 1);
        check("reset core_en", 32'(en_a), 0);
        check("reset busy", 32'(busy_a), 0);
        check("reset done", 32'(done_a), 0);
        check("reset done_cause", 32'(cause_a), 0);
        check("reset cycle_count", 32'(cnt_a), 0);

        reset = 1'b0;
        tick();
        check("post-reset core_reset", 32'(crst_a), 0);
        check("idle load_ready", 32'(bus_a.load_ready), 1);

        // Cycle limit of 5 on a non-halting two-word loop.
        load(1, 4'd0, 8'h01);
        load(1, 4'd1, 8'hC0);
        expect_done(1, "timeout", 2'b10, 16'd5, 8'd1, 8'd0);
        start_b = 1'b1; tick(); start_b = 1'b0;
        wait_done(1, "timeout", 40);

        // Sum program: r2 = 9+8+...+1, 34 enabled cycles, halts on JUMP 10.
        for (int i = 0; i < 11; i++) load(0, 4'(i), sum_prog[i]);
        expect_done(0, "sum", 2'b00, 16'd34, 8'd10, 8'd45);
        start_a = 1'b1; tick(); start_a = 1'b0;
        wait_done(0, "sum", 200);
        check("sum instr at halt", 32'(instr_a), 32'h0CA);
        check("done load_ready", 32'(bus_a.load_ready), 1);
        check("done busy", 32'(busy_a), 0);

        // JUMP 0 at address 0, written in the same cycle as start.
        expect_done(0, "self_jump0", 2'b00, 16'd0, 8'd0, 8'd0);
        bus_a.load_valid = 1'b1; bus_a.load_addr = 4'd0; bus_a.load_data = 8'hC0;
        start_a = 1'b1;
        tick();
        bus_a.load_valid = 1'b0; start_a = 1'b0;
        check("clear busy", 32'(busy_a), 1);
        check("clear core_reset", 32'(crst_a), 1);
        check("clear core_en", 32'(en_a), 0);
        check("clear cycle_count", 32'(cnt_a), 0);
        check("clear load_ready", 32'(bus_a.load_ready), 0);
        check("clear done_cause", 32'(cause_a), 0);
        tick();
        check("run1 done", 32'(done_a), 0);
        check("run1 core_reset", 32'(crst_a), 0);
        check("halt core_en", 32'(en_a), 0);
        tick();
        check("done after two cycles", 32'(done_a), 1);

        // JUMP 15 then ADDI at 15: PC walks to 16.
        load(0, 4'd0, 8'hCF);
        load(0, 4'd15, 8'h01);
        expect_done(0, "pc_range", 2'b01, 16'd2, 8'd16, 8'd0);
        start_a = 1'b1; tick(); start_a = 1'b0;
        tick();
        check("pc0 core_en", 32'(en_a), 1);
        tick();
        tick();
        check("oor core_en", 32'(en_a), 0);
        check("oor instr", 32'(instr_a), 0);
        wait_done(0, "pc_range", 5);

        // Pause, three steps, then stop+step+resume together.
        load(0, 4'd0, 8'h01);
        load(0, 4'd1, 8'hC0);
        expect_done(0, "pause_step", 2'b11, 16'd7, 8'd1, 8'd0);
        start_a = 1'b1; tick(); start_a = 1'b0;
        tick();
        repeat (4) tick();
        check("run count", 32'(cnt_a), 4);
        pause = 1'b1;
        tick();
        check("pause entry count", 32'(cnt_a), 4);
        check("pause core_en", 32'(en_a), 0);
        check("pause busy", 32'(busy_a), 1);
        repeat (2) tick();
        check("pause hold count", 32'(cnt_a), 4);
        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            #1;
            check("step core_en", 32'(en_a), 1);
            tick();
            step = 1'b0;
            tick();
        end
        check("steps count", 32'(cnt_a), 7);
        stop = 1'b1; step = 1'b1; resume = 1'b1;
        tick();
        stop = 1'b0; step = 1'b0; resume = 1'b0; pause = 1'b0;
        tick();
        check("done hold count", 32'(cnt_a), 7);
        check("done hold cause", 32'(cause_a), 3);

        // Load attempt during RUN, start ignored in RUN, then reset mid-run.
        start_a = 1'b1; tick(); start_a = 1'b0;
        tick();
        repeat (2) tick();
        start_a = 1'b1; tick(); start_a = 1'b0;
        check("start ignored in run", 32'(cnt_a), 3);
        bus_a.load_valid = 1'b1; bus_a.load_addr = 4'd0; bus_a.load_data = 8'hC0;
        #1;
        check("run load_ready", 32'(bus_a.load_ready), 0);
        tick();
        tick();
        bus_a.load_valid = 1'b0;
        check("run after load count", 32'(cnt_a), 5);
        check("run after load busy", 32'(busy_a), 1);
        reset = 1'b1;
        #1;
        check("midrun reset busy", 32'(busy_a), 0);
        check("midrun reset done", 32'(done_a), 0);
        check("midrun reset count", 32'(cnt_a), 0);
        check("midrun reset core_reset", 32'(crst_a), 1);
        tick();
        tick();
        check("mem preserved", 32'(instr_a), 32'h001);
        reset = 1'b0;
        tick();
        check("idle after reset busy", 32'(busy_a), 0);
        check("idle after reset core_reset", 32'(crst_a), 0);
        check("idle after reset load_ready", 32'(bus_a.load_ready), 1);

        repeat (3) tick();
        check("pending dut_a results", q_a.size(), 0);
        check("pending dut_b results", q_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
